// File: rtl/ddr_burst_fifo_filler.sv
// ddr_burst_fifo_filler
//
// Purpose:
//   Write-side producer for the 256-bit-in / 16-bit-out video line FIFO. It walks a frame buffer in
//   DDR by issuing read-burst requests, one at a time. Each returned 256-bit beat is forwarded to the
//   FIFO write port through one register stage. A new request is issued only when the FIFO
//   write-side level leaves room for a full burst, so the FIFO cannot overflow in normal operation.
//   The block runs entirely in the DDR user-clock domain.
//
// Ports:
//   i_wr_clk                DDR user clock (only clock)
//   i_wr_rst                asynchronous active-high reset
//   i_frame_start           1-cycle pulse: read the frame starting at BASE_ADDR
//   o_rd_req_valid          burst request valid (REQ state only)
//   i_rd_req_ready          DDR port accepts the request
//   o_rd_req_addr           burst start byte address
//   o_rd_req_len            burst length minus 1
//   i_rd_data_valid         returned beat valid (no backpressure)
//   i_rd_data               returned beat
//   i_rd_data_last          final beat of the burst
//   o_fifo_wr_en            FIFO write enable (rd_data_valid delayed 1 cycle)
//   o_fifo_wr_data          FIFO write data (rd_data delayed 1 cycle)
//   i_fifo_wr_full          FIFO full flag
//   i_fifo_wr_water_level   FIFO write-side fill level
//   o_busy                  frame read in progress
//   o_overflow_err          sticky: a beat arrived while the FIFO was full

module ddr_burst_fifo_filler #(
  parameter int unsigned           ADDR_WIDTH  = 28,
  parameter int unsigned           DATA_WIDTH  = 256,
  parameter int unsigned           LEVEL_WIDTH = 9,
  parameter int unsigned           FIFO_DEPTH  = 256,
  parameter int unsigned           BURST_LEN   = 16,
  parameter int unsigned           BEAT_BYTES  = 32,
  parameter int unsigned           FRAME_BEATS = 129600,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                   i_wr_clk,
  input  logic                   i_wr_rst,
  input  logic                   i_frame_start,
  output logic                   o_rd_req_valid,
  input  logic                   i_rd_req_ready,
  output logic [ADDR_WIDTH-1:0]  o_rd_req_addr,
  output logic [7:0]             o_rd_req_len,
  input  logic                   i_rd_data_valid,
  input  logic [DATA_WIDTH-1:0]  i_rd_data,
  input  logic                   i_rd_data_last,
  output logic                   o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]  o_fifo_wr_data,
  input  logic                   i_fifo_wr_full,
  input  logic [LEVEL_WIDTH-1:0] i_fifo_wr_water_level,
  output logic                   o_busy,
  output logic                   o_overflow_err
);

  localparam int unsigned REM_WIDTH    = $clog2(FRAME_BEATS + 1);
  localparam int unsigned LEVEL_THRESH = FIFO_DEPTH - BURST_LEN;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StReq,
    StWaitData,
    StSettle
  } state_t;

  // State registers
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [REM_WIDTH-1:0]  r_remain;
  logic [7:0]            r_len;
  logic                  r_restart_pend;
  logic                  r_busy;
  logic                  r_settle;

  // Data path registers
  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_overflow;

  // Next-state values
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [REM_WIDTH-1:0]  w_remain_nxt;
  logic [7:0]            w_len_nxt;
  logic                  w_restart_nxt;
  logic                  w_busy_nxt;
  logic                  w_settle_nxt;

  // Helpers
  logic                  w_restart_now;
  logic [REM_WIDTH-1:0]  w_remain_eval;
  logic [ADDR_WIDTH-1:0] w_addr_eval;
  logic [31:0]           w_take;
  logic                  w_level_ok;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [REM_WIDTH-1:0]  w_beats_req;

  // A pending restart is consumed in CHECK; the reloaded address/count are used for this
  // cycle's decision so no extra CHECK cycle is spent.
  assign w_restart_now = (r_state == StCheck) && r_restart_pend;
  assign w_remain_eval = w_restart_now ? REM_WIDTH'(FRAME_BEATS) : r_remain;
  assign w_addr_eval   = w_restart_now ? BASE_ADDR : r_addr;

  // Beats for the next request: min(BURST_LEN, remain)
  assign w_take     = (32'(w_remain_eval) >= BURST_LEN) ? BURST_LEN : 32'(w_remain_eval);
  assign w_level_ok = 32'(i_fifo_wr_water_level) <= LEVEL_THRESH;

  // Address wraps modulo 2^ADDR_WIDTH through truncation
  assign w_addr_inc  = ADDR_WIDTH'((32'(r_len) + 32'd1) * BEAT_BYTES);
  assign w_beats_req = REM_WIDTH'(32'(r_len) + 32'd1);

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_remain_nxt   = r_remain;
    w_len_nxt      = r_len;
    w_restart_nxt  = r_restart_pend;
    w_busy_nxt     = r_busy;
    w_settle_nxt   = r_settle;
    o_rd_req_valid = 1'b0;

    // frame_start during a frame never aborts; it is remembered for the next CHECK.
    // A pulse coinciding with the reload is absorbed.
    if (i_frame_start && r_busy && !w_restart_now) begin
      w_restart_nxt = 1'b1;
    end

    unique case (r_state)
      StIdle: begin
        if (i_frame_start) begin
          w_addr_nxt   = BASE_ADDR;
          w_remain_nxt = REM_WIDTH'(FRAME_BEATS);
          w_busy_nxt   = 1'b1;
          w_state_nxt  = StCheck;
        end
      end

      StCheck: begin
        if (w_restart_now) begin
          w_restart_nxt = 1'b0;
          w_addr_nxt    = w_addr_eval;
          w_remain_nxt  = w_remain_eval;
        end
        if (w_remain_eval == '0) begin
          // A restart latched this very cycle keeps the frame alive; it reloads next cycle.
          if (!w_restart_nxt) begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = StIdle;
          end
        end else if (w_level_ok) begin
          w_len_nxt   = 8'(w_take - 32'd1);
          w_state_nxt = StReq;
        end
      end

      StReq: begin
        o_rd_req_valid = 1'b1;
        if (i_rd_req_ready) begin
          w_addr_nxt   = r_addr + w_addr_inc;
          w_remain_nxt = r_remain - w_beats_req;
          w_state_nxt  = StWaitData;
        end
      end

      StWaitData: begin
        // The burst ends on rd_data_last alone; a beat-count mismatch is not acted upon.
        if (i_rd_data_valid && i_rd_data_last) begin
          w_settle_nxt = 1'b0;
          w_state_nxt  = StSettle;
        end
      end

      StSettle: begin
        // Two cycles so the FIFO level includes the final write before it is re-evaluated
        if (r_settle) begin
          w_state_nxt = StCheck;
        end else begin
          w_settle_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_wr_clk or posedge i_wr_rst) begin
    if (i_wr_rst) begin
      r_state        <= StIdle;
      r_addr         <= '0;
      r_remain       <= '0;
      r_len          <= '0;
      r_restart_pend <= 1'b0;
      r_busy         <= 1'b0;
      r_settle       <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_addr         <= w_addr_nxt;
      r_remain       <= w_remain_nxt;
      r_len          <= w_len_nxt;
      r_restart_pend <= w_restart_nxt;
      r_busy         <= w_busy_nxt;
      r_settle       <= w_settle_nxt;
    end
  end

  // Beats are forwarded regardless of FSM state; an overflowing beat is still presented
  // and the FIFO drops it.
  always_ff @(posedge i_wr_clk or posedge i_wr_rst) begin
    if (i_wr_rst) begin
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_en   <= i_rd_data_valid;
      r_wr_data <= i_rd_data;
      if (i_rd_data_valid && i_fifo_wr_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_rd_req_addr  = r_addr;
  assign o_rd_req_len   = r_len;
  assign o_fifo_wr_en   = r_wr_en;
  assign o_fifo_wr_data = r_wr_data;
  assign o_busy         = r_busy;
  assign o_overflow_err = r_overflow;

endmodule

// File: tb/tb_ddr_burst_fifo_filler.sv
// Testbench for ddr_burst_fifo_filler: a DDR read-port responder returns random beats for every
// accepted request; expected requests and beats are queued and compared when the DUT emits them.

module tb_ddr_burst_fifo_filler;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 256;
  localparam int unsigned LW = 9;
  localparam int unsigned FB = 40;
  localparam int unsigned BL = 16;

  logic          wr_clk;
  logic          wr_rst;
  logic          frame_start;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic [7:0]    rd_req_len;
  logic          rd_data_valid;
  logic [DW-1:0] rd_data;
  logic          rd_data_last;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          fifo_wr_full;
  logic [LW-1:0] fifo_wr_water_level;
  logic          busy;
  logic          overflow_err;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_count = 0;
  int req_count = 0;

  logic [AW-1:0] req_addr_q[$];
  logic [7:0]    req_len_q[$];
  logic [DW-1:0] data_q[$];

  ddr_burst_fifo_filler #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LEVEL_WIDTH(LW),
    .FIFO_DEPTH (256),
    .BURST_LEN  (BL),
    .BEAT_BYTES (32),
    .FRAME_BEATS(FB),
    .BASE_ADDR  ('0)
  ) u_dut (
    .i_wr_clk             (wr_clk),
    .i_wr_rst             (wr_rst),
    .i_frame_start        (frame_start),
    .o_rd_req_valid       (rd_req_valid),
    .i_rd_req_ready       (rd_req_ready),
    .o_rd_req_addr        (rd_req_addr),
    .o_rd_req_len         (rd_req_len),
    .i_rd_data_valid      (rd_data_valid),
    .i_rd_data            (rd_data),
    .i_rd_data_last       (rd_data_last),
    .o_fifo_wr_en         (fifo_wr_en),
    .o_fifo_wr_data       (fifo_wr_data),
    .i_fifo_wr_full       (fifo_wr_full),
    .i_fifo_wr_water_level(fifo_wr_water_level),
    .o_busy               (busy),
    .o_overflow_err       (overflow_err)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic push_frame_reqs();
    req_addr_q.push_back(28'h000); req_len_q.push_back(8'd15);
    req_addr_q.push_back(28'h200); req_len_q.push_back(8'd15);
    req_addr_q.push_back(28'h400); req_len_q.push_back(8'd7);
  endtask

  task automatic pulse_start();
    @(posedge wr_clk); #1 frame_start = 1'b1;
    @(posedge wr_clk); #1 frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge wr_clk);
      n++;
    end while (busy && n < 2000);
    check_eq(tag, busy, 1'b0);
  endtask

  task automatic wait_reqs(input int target, input string tag);
    int n;
    n = 0;
    while (req_count < target && n < 500) begin
      @(negedge wr_clk);
      n++;
    end
    check_eq(tag, req_count >= target, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req_valid"}, rd_req_valid, 1'b0);
    check_eq({tag, "_req_addr"}, rd_req_addr, '0);
    check_eq({tag, "_req_len"}, rd_req_len, '0);
    check_eq({tag, "_wr_en"}, fifo_wr_en, 1'b0);
    check_eq({tag, "_wr_data"}, fifo_wr_data, '0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_overflow"}, overflow_err, 1'b0);
  endtask

  // DDR read-port model: answers each accepted request with len+1 random beats
  initial begin : responder
    logic [AW-1:0] a;
    logic [7:0]    l;
    logic [DW-1:0] d;
    rd_data_valid = 1'b0;
    rd_data       = '0;
    rd_data_last  = 1'b0;
    forever begin
      @(negedge wr_clk);
      if (!wr_rst && rd_req_valid && rd_req_ready) begin
        a = rd_req_addr;
        l = rd_req_len;
        req_count++;
        if (req_addr_q.size() == 0) begin
          check_eq("req_unexpected", 1'b1, 1'b0);
        end else begin
          check_eq("req_addr", a, req_addr_q.pop_front());
          check_eq("req_len", l, req_len_q.pop_front());
        end
        @(posedge wr_clk);
        for (int k = 0; k <= int'(l); k++) begin
          @(posedge wr_clk); #1;
          if (wr_rst) begin
            rd_data_valid = 1'b0;
            rd_data_last  = 1'b0;
            data_q.delete();
            req_addr_q.delete();
            req_len_q.delete();
            break;
          end
          for (int w = 0; w < int'(DW / 32); w++) d[w*32 +: 32] = $urandom;
          rd_data_valid = 1'b1;
          rd_data       = d;
          rd_data_last  = (k == int'(l));
          data_q.push_back(d);
        end
        @(posedge wr_clk); #1;
        rd_data_valid = 1'b0;
        rd_data_last  = 1'b0;
      end
    end
  end

  // FIFO write-port monitor
  initial begin : monitor
    logic [DW-1:0] e;
    forever begin
      @(negedge wr_clk);
      if (fifo_wr_en) begin
        wr_count++;
        if (data_q.size() == 0) begin
          check_eq("wr_spurious", 1'b1, 1'b0);
        end else begin
          e = data_q.pop_front();
          check_eq("wr_data", fifo_wr_data, e);
        end
      end
    end
  end

  initial begin : main
    int base;
    int rc0;
    int seen;
    wr_rst              = 1'b1;
    frame_start         = 1'b0;
    rd_req_ready        = 1'b0;
    fifo_wr_full        = 1'b0;
    fifo_wr_water_level = '0;

    // Reset state
    repeat (3) @(negedge wr_clk);
    check_all_zero("reset");
    @(posedge wr_clk); #1 wr_rst = 1'b0;

    // Full 40-beat frame: 16 + 16 + 8
    rd_req_ready = 1'b1;
    push_frame_reqs();
    base = wr_count;
    pulse_start();
    wait_idle("frame_busy_fall");
    check_eq("frame_wr_count", wr_count - base, 40);
    check_eq("frame_reqs_left", req_addr_q.size(), 0);
    check_eq("frame_beats_left", data_q.size(), 0);

    // Water-level pacing: 241 blocks, 240 releases
    fifo_wr_water_level = 9'd241;
    push_frame_reqs();
    base = wr_count;
    pulse_start();
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge wr_clk);
      if (rd_req_valid) seen++;
    end
    check_eq("level241_no_req", seen, 0);
    @(posedge wr_clk); #1 fifo_wr_water_level = 9'd240;
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge wr_clk);
      if (rd_req_valid) seen = 1;
    end
    check_eq("level240_req", seen, 1);
    wait_idle("level_busy_fall");
    check_eq("level_wr_count", wr_count - base, 40);
    fifo_wr_water_level = '0;

    // Request held stable while ready is low
    rd_req_ready = 1'b0;
    push_frame_reqs();
    base = wr_count;
    pulse_start();
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge wr_clk);
      if (rd_req_valid) seen = 1;
    end
    check_eq("hold_req_seen", seen, 1);
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_req", {rd_req_valid, rd_req_addr, rd_req_len}, {1'b1, 28'h000, 8'd15});
      @(negedge wr_clk);
    end
    @(posedge wr_clk); #1 rd_req_ready = 1'b1;
    wait_idle("hold_busy_fall");
    check_eq("hold_wr_count", wr_count - base, 40);

    // Restart during the second burst: burst completes, frame reloads, busy stays high
    push_frame_reqs();
    req_addr_q.delete(2); req_len_q.delete(2);
    push_frame_reqs();
    base = wr_count;
    rc0  = req_count;
    pulse_start();
    wait_reqs(rc0 + 2, "restart_second_req");
    repeat (3) @(posedge wr_clk);
    pulse_start();
    wait_idle("restart_busy_fall");
    check_eq("restart_wr_count", wr_count - base, 16 + 16 + 40);
    check_eq("restart_req_count", req_count - rc0, 5);
    check_eq("restart_reqs_left", req_addr_q.size(), 0);

    // Reset mid-burst, then a clean frame from BASE_ADDR
    push_frame_reqs();
    rc0 = req_count;
    pulse_start();
    wait_reqs(rc0 + 1, "rst_first_req");
    repeat (5) @(posedge wr_clk);
    #2 wr_rst = 1'b1;
    @(negedge wr_clk);
    check_all_zero("midrst");
    repeat (2) @(posedge wr_clk);
    #1 wr_rst = 1'b0;
    push_frame_reqs();
    base = wr_count;
    pulse_start();
    wait_idle("rst_busy_fall");
    check_eq("rst_wr_count", wr_count - base, 40);
    check_eq("rst_reqs_left", req_addr_q.size(), 0);

    // Overflow is sticky across frames and cleared only by reset
    fifo_wr_full = 1'b1;
    push_frame_reqs();
    pulse_start();
    wait_idle("ovf_busy_fall");
    check_eq("ovf_set", overflow_err, 1'b1);
    fifo_wr_full = 1'b0;
    push_frame_reqs();
    pulse_start();
    wait_idle("ovf_frame2_busy_fall");
    check_eq("ovf_sticky", overflow_err, 1'b1);
    @(posedge wr_clk); #1 wr_rst = 1'b1;
    @(negedge wr_clk);
    check_eq("ovf_cleared", overflow_err, 1'b0);
    @(posedge wr_clk); #1 wr_rst = 1'b0;
    repeat (2) @(negedge wr_clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
